// File: rtl/lp_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : lp_stream_fifo
//  Purpose  : First-word-fall-through stream FIFO with occupancy output.
//             Optional per-word last flag via LP_STREAM_FIFO_LAST_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lp_stream_fifo #(
    parameter  int DATAW = 32,
    parameter  int DEPTH = 16,
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DATAW-1:0] s_data,
`ifdef LP_STREAM_FIFO_LAST_EN
    input  logic             s_last,
    output logic             m_last,
    output logic [CNTW-1:0]  pkt_count,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DATAW-1:0] m_data,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);
`ifdef LP_STREAM_FIFO_LAST_EN
    localparam int c_MEMW = DATAW + 1;
`else
    localparam int c_MEMW = DATAW;
`endif
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;
    localparam logic [CNTW-1:0] c_CNT_ONE = 1;
    localparam logic [CNTW-1:0] c_CNT_FULL = CNTW'(DEPTH);

    logic [c_MEMW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic              w_push;
    logic              w_pop;
    logic [c_MEMW-1:0] w_wr_word;
    logic [c_MEMW-1:0] w_head;

    assign full    = (r_count == c_CNT_FULL);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    // Gated by aresetn so no word can be accepted while reset is held.
    assign s_ready = !full && aresetn;
    assign m_valid = !empty;
    assign w_head  = r_mem[r_rd_ptr];
    assign m_data  = w_head[DATAW-1:0];

    assign w_push = s_valid && s_ready;
    assign w_pop  = m_valid && m_ready;

`ifdef LP_STREAM_FIFO_LAST_EN
    assign w_wr_word = {s_last, s_data};
    assign m_last    = m_valid && w_head[DATAW];
`else
    assign w_wr_word = s_data;
`endif

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LP_STREAM_FIFO_LAST_EN
    logic [CNTW-1:0] r_pkt_count;
    logic            w_push_last;
    logic            w_pop_last;

    assign w_push_last = w_push && s_last;
    assign w_pop_last  = w_pop && m_last;
    assign pkt_count   = r_pkt_count;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_pkt_count <= '0;
        end else begin
            case ({w_push_last, w_pop_last})
                2'b10:   r_pkt_count <= r_pkt_count + c_CNT_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - c_CNT_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lp_stream_fifo.sv
`default_nettype none
// Directed and scoreboarded checks for lp_stream_fifo (DATAW=32, DEPTH=16).
module tb_lp_stream_fifo;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef LP_STREAM_FIFO_LAST_EN
    logic        s_last;
    logic        m_last;
    logic [4:0]  pkt_count;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    lp_stream_fifo #(.DATAW(32), .DEPTH(16)) dut (
        .aclk     (clk),
        .aresetn  (aresetn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
`ifdef LP_STREAM_FIFO_LAST_EN
        .s_last   (s_last),
        .m_last   (m_last),
        .pkt_count(pkt_count),
`endif
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
`ifdef LP_STREAM_FIFO_LAST_EN
        s_last  = 1'b0;
`endif
        step();
        step();
        vectors++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready_low got=%b exp=0", s_ready); end
        vectors++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b exp 1/0", empty, full); end
        vectors++;
        if (count !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        aresetn = 1'b1;
        step();
        vectors++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got=%b exp=1", s_ready); end
        vectors++;
        if (m_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL post_rst_idle got m_valid=%b empty=%b count=%0d exp 0/1/0", m_valid, empty, count);
        end
    endtask

    task automatic test_fill_drain();
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            step();
        end
        vectors++;
        if (count !== 5'd16 || full !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL fill_full got count=%0d full=%b s_ready=%b exp 16/1/0", count, full, s_ready);
        end
        s_data = 32'hDEAD_BEEF;
        step();
        s_valid = 1'b0;
        vectors++;
        if (count !== 5'd16 || m_data !== 32'd1) begin
            errors++; $display("FAIL overflow_refused got count=%0d head=%h exp 16/00000001", count, m_data);
        end
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
                errors++; $display("FAIL drain_word got valid=%b data=%h exp 1/%h", m_valid, m_data, 32'(i));
            end
            step();
        end
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got empty=%b count=%0d m_valid=%b exp 1/0/0", empty, count, m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        m_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h200 + 32'(i);
            step();
        end
        s_data  = 32'h2FF;
        m_ready = 1'b1;
        vectors++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL full_pp_s_ready got=%b exp=0", s_ready); end
        step();
        vectors++;
        if (count !== 5'd15 || s_ready !== 1'b1 || m_data !== 32'h202) begin
            errors++; $display("FAIL full_pp_pop_only got count=%0d s_ready=%b head=%h exp 15/1/00000202", count, s_ready, m_data);
        end
        m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        vectors++;
        if (count !== 5'd16) begin errors++; $display("FAIL full_pp_retry got count=%0d exp=16", count); end
        m_ready = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            logic [31:0] exp_d;
            exp_d = (i == 17) ? 32'h2FF : 32'h200 + 32'(i);
            vectors++;
            if (m_valid !== 1'b1 || m_data !== exp_d) begin
                errors++; $display("FAIL full_pp_drain got valid=%b data=%h exp 1/%h", m_valid, m_data, exp_d);
            end
            step();
        end
        vectors++;
        if (empty !== 1'b1) begin errors++; $display("FAIL full_pp_empty got=%b exp=1", empty); end
        m_ready = 1'b0;
    endtask

    task automatic test_streaming();
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s_data = 32'h100 + 32'(k);
            if (k > 0) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== 32'h100 + 32'(k - 1)) begin
                    errors++; $display("FAIL stream_word got valid=%b data=%h exp 1/%h", m_valid, m_data, 32'h100 + 32'(k - 1));
                end
            end
            step();
            vectors++;
            if (count !== 5'd1) begin errors++; $display("FAIL stream_count got=%0d exp=1", count); end
        end
        s_valid = 1'b0;
        vectors++;
        if (m_data !== 32'h127) begin errors++; $display("FAIL stream_last got=%h exp=00000127", m_data); end
        step();
        vectors++;
        if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] off_data;
        logic [31:0] prev_data;
        logic        off;
        logic        prev_stall;
        logic        do_push;
        logic        do_pop;
        int          nxt;
        int          cyc;
        off        = 1'b0;
        off_data   = '0;
        prev_data  = '0;
        prev_stall = 1'b0;
        nxt        = 0;
        cyc        = 0;
        while ((nxt < 1000 || q.size() != 0) && cyc < 6000) begin
            vectors++;
            if (m_valid !== (q.size() != 0) || count !== 5'(q.size())) begin
                errors++; $display("FAIL rand_state got valid=%b count=%0d exp %b/%0d", m_valid, count, q.size() != 0, q.size());
            end
            if (q.size() != 0) begin
                vectors++;
                if (m_data !== q[0]) begin errors++; $display("FAIL rand_data got=%h exp=%h", m_data, q[0]); end
            end
            if (prev_stall) begin
                vectors++;
                if (m_data !== prev_data) begin errors++; $display("FAIL rand_stable got=%h exp=%h", m_data, prev_data); end
            end
            if (!off && nxt < 1000 && $urandom_range(0, 1) == 1) begin
                off      = 1'b1;
                off_data = 32'h1000_0000 + 32'(nxt);
            end
            s_valid = off;
            s_data  = off_data;
            m_ready = ($urandom_range(0, 1) == 1);
            do_push = off && (q.size() < 16);
            do_pop  = m_ready && (q.size() != 0);
            prev_stall = (q.size() != 0) && !m_ready;
            prev_data  = (q.size() != 0) ? q[0] : '0;
            step();
            cyc++;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(off_data);
                nxt++;
                off = 1'b0;
            end
        end
        vectors++;
        if (cyc >= 6000) begin errors++; $display("FAIL rand_timeout got cycles=%0d exp <6000", cyc); end
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h300 + 32'(i);
            step();
        end
        s_valid = 1'b0;
        vectors++;
        if (count !== 5'd7) begin errors++; $display("FAIL mid_rst_pre got count=%0d exp=7", count); end
        aresetn = 1'b0;
        step();
        vectors++;
        if (count !== 5'd0 || m_valid !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL mid_rst_clear got count=%0d m_valid=%b empty=%b exp 0/0/1", count, m_valid, empty);
        end
        vectors++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready got=%b exp=0", s_ready); end
        aresetn = 1'b1;
        step();
        vectors++;
        if (s_ready !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL mid_rst_after got s_ready=%b count=%0d exp 1/0", s_ready, count);
        end
    endtask

`ifdef LP_STREAM_FIFO_LAST_EN
    task automatic test_last();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h400 + 32'(i);
            s_last  = (i == 2);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        vectors++;
        if (pkt_count !== 5'd1) begin errors++; $display("FAIL last_pkt_count got=%0d exp=1", pkt_count); end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (m_last !== (i == 2)) begin errors++; $display("FAIL last_flag got=%b exp=%b", m_last, i == 2); end
            step();
        end
        vectors++;
        if (pkt_count !== 5'd0 || m_last !== 1'b0) begin
            errors++; $display("FAIL last_after got pkt_count=%0d m_last=%b exp 0/0", pkt_count, m_last);
        end
        m_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_streaming();
        test_random();
        test_mid_reset();
`ifdef LP_STREAM_FIFO_LAST_EN
        test_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lp_stream_fifo.md
Name: lp_stream_fifo

Overview:
- Synchronous first-word-fall-through FIFO carrying 32-bit axi_stream words (valid/ready/data) between LP datapath stages.
- Sits directly upstream of an axi_stream_port "in" consumer; decouples producer bursts (e.g. tableau row readout) from consumer backpressure.
- Exposes occupancy for flow-control and debug.

Parameters:
- DATAW, 32, payload width in bits; matches the axi_stream data width.
- DEPTH, 16, number of entries; power of two, minimum 2.
- CNTW, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- aclk  input  1  clock; all logic on the rising edge.
- aresetn  input  1  synchronous, active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  FIFO can accept a word.
- s_data  input  DATAW  upstream payload.
- m_valid  output  1  head word available.
- m_ready  input  1  downstream accepts the head word.
- m_data  output  DATAW  head payload.
- count  output  CNTW  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (aresetn low at a clock edge): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, s_ready=0 during reset and 1 on the first cycle after, m_valid=0. m_data is don't-care while m_valid=0. The storage array is not reset.
- Reset mid-operation discards all stored words. There is no partial flush.
- Push: s_valid && s_ready at an edge. s_data is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: m_valid && m_ready at an edge. rd_ptr increments modulo DEPTH.
- s_ready = !full, decoded from registered state with no combinational path from m_ready. A full FIFO refuses a push even when a pop happens in the same cycle.
- m_valid = !empty. m_data = mem[rd_ptr], so the head word is presented without a request.
- Latency: a word pushed at edge N is visible on m_valid/m_data after edge N. This is 1 cycle, including the empty case; there is no combinational bypass.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push only: count+1. Pop only: count-1.
- Pointers are log2(DEPTH) bits and wrap naturally. full/empty derive from count, not pointer compare.
- Handshake rules the FIFO honours:
  - m_valid never drops without a pop.
  - m_data is stable while m_valid && !m_ready.
- Input protocol assumption: s_valid/s_data are held by upstream until accepted. The FIFO does not check this.
- Order is strictly preserved; no word is duplicated or dropped.

Optional Feature:
- Macro: LP_STREAM_FIFO_LAST_EN.
- Defined:
  - Adds ports s_last (input 1) and m_last (output 1), stored per entry alongside data.
  - Adds output pkt_count (CNTW), the number of stored words with last=1. It increments on a push with s_last=1 and decrements on a pop with m_last=1; both together leave it unchanged.
  - Reset value of pkt_count and m_last is 0.
- Undefined: no last storage or ports; the array is DATAW wide.

Test Plan:
- Reset then idle, m_ready=1 -> m_valid=0, empty=1, count=0, s_ready=1 from the first post-reset cycle.
- Push 0x0000_0001..0x0000_0010 (16 words) with m_ready=0 -> count=16, full=1, s_ready=0. A 17th offered word 0xDEAD_BEEF is not accepted. Then drain with m_ready=1 -> outputs 1..16 in order, one per cycle, then empty=1.
- Full FIFO, s_valid=1 and m_ready=1 in the same cycle -> the pop occurs, the push is refused, and count goes 16->15. On the next cycle s_ready=1 and the push is accepted.
- Continuous streaming, s_valid=1 and m_ready=1 for 40 cycles with incrementing data starting at 0x100 -> count steady at 1 after the first cycle, output 0x100.. in order, pointers wrap twice with no loss.
- Random m_ready (50%) and random s_valid over 1000 words -> scoreboard matches exactly. m_data is stable whenever m_valid && !m_ready.
- Assert aresetn low for one cycle with count=7 -> next cycle count=0, m_valid=0. With LP_STREAM_FIFO_LAST_EN: push 3 words, last=1 on the 3rd -> pkt_count=1. After 3 pops, m_last=1 on the 3rd word and pkt_count=0.
